// File: rtl/alu_op_issue_if.sv
// +----------------------------------------------------------------------------+
// | alu_op_issue_if : operand, ALU, and result bundle for alu_op_issue         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface alu_op_issue_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [1:0]       in_width;
  logic             in_saturate;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [1:0]       alu_width;
  logic             alu_saturate;
  logic [31:0]      alu_c;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             err_illegal;
  logic [15:0]      op_count;

  modport slave (
    input  in_valid, in_a, in_b, in_width, in_saturate, in_tag, alu_c, res_ready,
    output in_ready, alu_a, alu_b, alu_width, alu_saturate,
           res_valid, res_data, res_tag, err_illegal, op_count
  );

  modport master (
    output in_valid, in_a, in_b, in_width, in_saturate, in_tag, alu_c, res_ready,
    input  in_ready, alu_a, alu_b, alu_width, alu_saturate,
           res_valid, res_data, res_tag, err_illegal, op_count
  );
endinterface

`default_nettype wire

// File: rtl/alu_op_issue.sv
// +----------------------------------------------------------------------------+
// | alu_op_issue : operand FIFO feeding the SIMD ALU, registered result slot   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_op_issue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  alu_op_issue_if.slave bus
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = TAG_W + 3 + 64;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               res_valid_q, res_valid_d;
  logic [31:0]        res_data_q, res_data_d;
  logic [TAG_W-1:0]   res_tag_q, res_tag_d;
  logic               err_q, err_d;
  logic [15:0]        op_count_q, op_count_d;

  logic               full, empty, push, pop, slot_free, head_illegal;
  logic [ENTRY_W-1:0] head, wr_entry;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign push      = bus.in_valid && !full;
  assign slot_free = !res_valid_q || bus.res_ready;
  assign pop       = !empty && slot_free;
  assign head      = mem_q[rd_ptr_q];
  assign wr_entry  = {bus.in_tag, bus.in_saturate, bus.in_width, bus.in_a, bus.in_b};
  assign head_illegal = (head[65:64] == 2'd3);

  // ALU sees zeros while the FIFO is empty so stale entries never leak out.
  assign bus.alu_b        = empty ? 32'd0 : head[31:0];
  assign bus.alu_a        = empty ? 32'd0 : head[63:32];
  assign bus.alu_width    = empty ? 2'd0  : head[65:64];
  assign bus.alu_saturate = empty ? 1'b0  : head[66];

  assign bus.in_ready    = !full;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_tag     = res_tag_q;
  assign bus.err_illegal = err_q;
  assign bus.op_count    = op_count_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;
    err_d       = err_q;
    op_count_d  = op_count_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + (PTR_W + 1)'(1);
    else if (!push && pop) count_d = count_q - (PTR_W + 1)'(1);

    // A drain clears the slot; a legal issue in the same edge overrides it.
    if (res_valid_q && bus.res_ready) res_valid_d = 1'b0;
    if (pop) begin
      if (head_illegal) begin
        err_d = 1'b1;
      end else begin
        res_valid_d = 1'b1;
        res_data_d  = bus.alu_c;
        res_tag_d   = head[ENTRY_W-1:67];
        op_count_d  = op_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      err_q       <= 1'b0;
      op_count_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
      err_q       <= err_d;
      op_count_q  <= op_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end
endmodule

`default_nettype wire

// File: doc/alu_op_issue.md
Name: alu_op_issue

Overview:
Upstream issue stage for the SIMD saturating ALU (8/16/32-bit lanes, wrap or saturate). It buffers operand packets in a small FIFO and presents the FIFO head directly on the ALU input ports. It registers the ALU result together with a caller tag into a valid/ready result slot. It also flags illegal width codes and counts completed operations.

Parameters:
DEPTH, 4, operand FIFO entries; must be a power of 2 and at least 2
TAG_W, 4, width of the caller tag carried alongside each operation

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand packet valid
in_ready  output  1  FIFO can accept a packet; equals !full
in_a  input  32  operand a
in_b  input  32  operand b
in_width  input  2  lane width code: 0=4x8-bit, 1=2x16-bit, 2=1x32-bit, 3=illegal
in_saturate  input  1  1=signed saturate, 0=wrap
in_tag  input  TAG_W  caller tag
alu_a  output  32  to ALU a
alu_b  output  32  to ALU b
alu_width  output  2  to ALU width
alu_saturate  output  1  to ALU saturate
alu_c  input  32  ALU result (combinational from alu_* outputs)
res_valid  output  1  result slot holds a result
res_ready  input  1  consumer accepts the result
res_data  output  32  registered ALU result
res_tag  output  TAG_W  tag of the result
err_illegal  output  1  sticky; an op with width=3 was dropped
op_count  output  16  number of results produced; wraps mod 2^16

Behaviour:
- Reset: the following are all 0:
  - FIFO read and write pointers and occupancy count
  - res_valid, res_data, res_tag
  - err_illegal, op_count
- Reset mid-operation flushes all queued and held ops; nothing is emitted afterwards.
- Push: accept when in_valid && in_ready. The entry {tag, saturate, width, a, b} is written at the tail.
  - No push while full.
  - No empty-FIFO bypass: a pushed entry becomes the head at the earliest on the next cycle.
- ALU drive: alu_* outputs are combinational from the FIFO head. When the FIFO is empty they are all 0.
- Slot free condition: slot_free = !res_valid || res_ready.
- Issue: when the FIFO is non-empty and slot_free, the head pops at the clock edge.
  - If the head width != 3: res_data <= alu_c, res_tag <= head tag, res_valid <= 1, op_count += 1.
  - If the head width == 3: the entry is popped and discarded. err_illegal <= 1. op_count is unchanged. res_valid <= 0 if the slot was drained this cycle, otherwise it holds.
- Drain: res_valid && res_ready with no issue in the same cycle gives res_valid <= 0. res_data and res_tag hold their last values.
- Simultaneous drain and issue: the new result replaces the old one in the same edge. Throughput is 1 op/cycle.
- Simultaneous push and pop: allowed whenever not full. Occupancy is unchanged.
- Latency: a packet accepted at edge N, with an empty FIFO and a free slot, gives res_valid high after edge N+1.
- Backpressure capacity: with res_ready=0, DEPTH+1 packets are accepted (1 in the result slot, DEPTH in the FIFO). The next packet stalls.
- Ordering: results appear in strict acceptance order. Dropped illegal ops leave no gap in the tag stream beyond their own absence.
- res_data, res_tag and res_valid are stable while res_valid && !res_ready.
- err_illegal clears only on rst.

Test Plan:
- Two pushes with res_ready=1 give res_data=0x80000000 then res_data=0x7FFFFFFF, with tags 1 and 2 in order:
  - push 1: a=0x7FFFFFFF, b=0x00000001, width=2, sat=0, tag=1
  - push 2: same operands with sat=1, tag=2
- Lane ops, one result per cycle, op_count=2 after both:
  - width=1, sat=0, a=0x0000FFFF, b=0x40000001 -> 0x40000000
  - width=0, sat=1, a=0x4000007F, b=0x00000001 -> 0x4000007F
- Backpressure: res_ready=0 and 6 back-to-back pushes (DEPTH=4).
  - Exactly 5 are accepted; in_ready goes low after the 5th; res_data holds the first result.
  - Raising res_ready drains all 5 in order on consecutive cycles.
- Illegal width: push width=3 (tag=7) between two legal ops.
  - err_illegal goes to 1 and no tag-7 result appears.
  - op_count advances by 2; the neighbouring results are correct.
- Reset mid-operation: assert rst for 1 cycle with 3 ops queued and res_valid=1.
  - Next cycle: res_valid=0, in_ready=1, op_count=0, err_illegal=0.
  - No queued op ever emerges.
- Idle after reset: with the FIFO empty, alu_a, alu_b, alu_width and alu_saturate are all 0, and res_valid stays 0 for 10 cycles.
